// File: rtl/uart_pkg.sv
// uart_pkg: shared state type, frame constants and baud divider helper
package uart_pkg;
  typedef enum logic [2:0] {ARM, IDLE, START, DATA, STOP} rx_state_t;
  localparam int UART_DATA_BITS = 8;
  function automatic int uart_div(input int clk, input int baud, input int os);
    return (clk + baud * os / 2) / (baud * os);
  endfunction
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: small synchronous byte buffer with show-ahead head output
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             rd,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_wr, do_rd;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign do_rd = rd && !empty;
  // a write into a full buffer is allowed only when the head leaves on the same clock
  assign do_wr = wr && (!full || do_rd);
  assign dout = mem[rp];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mem <= '{default: '0};
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (do_wr) mem[wp] <= din;
      if (do_wr) wp <= wp + 1'b1;
      if (do_rd) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling 8N1 receiver with byte FIFO, frame-error, overrun and break flags
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rxd,
  output logic [7:0] dout,
  output logic       dout_vld,
  input  logic       dout_rdy,
  output logic       frame_err,
  output logic       overrun,
  output logic       break_det,
  output logic       busy
);
  localparam int DIV = uart_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(UART_DATA_BITS);
  localparam int MID = OVERSAMPLE / 2;
  rx_state_t state, state_d;
  logic [1:0] sync, samp;
  logic rxd, rxd_q, fall, tick, decide, bit_end, maj, restart;
  logic [PW-1:0] presc;
  logic [TW-1:0] tcnt;
  logic [BW-1:0] bitcnt;
  logic [UART_DATA_BITS-1:0] shreg;
  logic wr, wr_q, ferr, brk, full, empty, rd;
  assign rxd = sync[1];
  assign fall = rxd_q && !rxd;
  assign tick = presc == PW'(DIV - 1);
  assign decide = tick && tcnt == TW'(MID + 1);
  assign bit_end = tick && tcnt == TW'(OVERSAMPLE - 1);
  assign maj = (samp[1] & samp[0]) | (samp[1] & rxd) | (samp[0] & rxd);
  // ARM needs an unbroken high bit, so any low sample restarts its timing
  assign restart = (state == IDLE && fall) || (state == ARM && !rxd);
  assign wr = state == STOP && decide && maj;
  assign ferr = state == STOP && decide && !maj && |shreg;
  assign brk = state == STOP && decide && !maj && ~|shreg;
  assign busy = state == START || state == DATA || state == STOP;
  assign dout_vld = !empty;
  assign rd = dout_rdy && dout_vld;
  always_comb begin
    state_d = state;
    case (state)
      ARM:     state_d = bit_end && rxd ? IDLE : ARM;
      IDLE:    state_d = fall ? START : IDLE;
      START:   state_d = decide && maj ? IDLE : bit_end ? DATA : START;
      DATA:    state_d = bit_end && bitcnt == BW'(UART_DATA_BITS - 1) ? STOP : DATA;
      STOP:    state_d = decide ? (maj ? IDLE : ARM) : STOP;
      default: state_d = ARM;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= ARM;
    else state <= state_d;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync <= 2'b11;
      rxd_q <= 1'b1;
      presc <= '0;
      tcnt <= '0;
      samp <= '0;
      bitcnt <= '0;
      shreg <= '0;
      wr_q <= 1'b0;
      frame_err <= 1'b0;
      break_det <= 1'b0;
      overrun <= 1'b0;
    end else begin
      sync <= {sync[0], uart_rxd};
      rxd_q <= rxd;
      presc <= restart || tick ? '0 : presc + 1'b1;
      tcnt <= restart ? '0 : !tick ? tcnt : bit_end ? '0 : tcnt + 1'b1;
      if (tick && tcnt == TW'(MID - 1)) samp[0] <= rxd;
      if (tick && tcnt == TW'(MID)) samp[1] <= rxd;
      if (state == DATA && decide) shreg <= {maj, shreg[UART_DATA_BITS-1:1]};
      bitcnt <= state == START ? '0 : state == DATA && bit_end ? bitcnt + 1'b1 : bitcnt;
      wr_q <= wr;
      frame_err <= ferr;
      break_det <= brk;
      overrun <= wr_q && full && !rd;
    end
  uart_rx_fifo #(.WIDTH(UART_DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .wr(wr_q), .din(shreg), .full(full),
    .rd(rd), .dout(dout), .empty(empty)
  );
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed 8N1 frames with a byte scoreboard and flag pulse counters
module tb_uart_rx;
  localparam int BIT = 432;
  logic clk = 1'b0, rst = 1'b1, uart_rxd = 1'b1, dout_rdy = 1'b1;
  logic [7:0] dout;
  logic dout_vld, frame_err, overrun, break_det, busy;
  int n_assert = 0, n_fail = 0;
  int fe_cnt, brk_cnt, ovr_cnt, xfer_cnt, vld_hi, busy_cnt;
  logic [7:0] q[$];
  logic [7:0] prev_dout = '0;
  logic prev_hold = 1'b0;

  always #10 clk = ~clk;

  uart_rx dut (
    .clk(clk), .rst(rst), .uart_rxd(uart_rxd), .dout(dout), .dout_vld(dout_vld),
    .dout_rdy(dout_rdy), .frame_err(frame_err), .overrun(overrun),
    .break_det(break_det), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear();
    fe_cnt = 0; brk_cnt = 0; ovr_cnt = 0; xfer_cnt = 0; vld_hi = 0; busy_cnt = 0;
  endtask

  // one clock: observe at the falling edge, return just after the rising edge
  task automatic step();
    @(negedge clk);
    if (dout_vld && dout_rdy) begin
      xfer_cnt++;
      chk("sb_expected", q.size() > 0, 1);
      if (q.size() > 0) chk("sb_byte", dout, q.pop_front());
    end
    if (prev_hold && dout_vld) chk("dout_hold", dout, prev_dout);
    prev_hold = dout_vld && !dout_rdy;
    prev_dout = dout;
    fe_cnt += int'(frame_err);
    brk_cnt += int'(break_det);
    ovr_cnt += int'(overrun);
    vld_hi += int'(dout_vld);
    busy_cnt += int'(busy);
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic send(input logic [7:0] b, input logic stop);
    uart_rxd = 1'b0;
    steps(BIT);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      steps(BIT);
    end
    uart_rxd = stop;
    steps(BIT);
    uart_rxd = 1'b1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_dout"}, dout, 8'h00);
    chk({tag, "_vld"}, dout_vld, 1'b0);
    chk({tag, "_flags"}, {frame_err, overrun, break_det}, 3'b000);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    clear();
    steps(3);
    chk_reset_outputs("reset");
    rst = 1'b0;

    // 1: plain byte with consumer ready
    steps(2 * BIT);
    clear();
    q.push_back(8'h55);
    send(8'h55, 1'b1);
    steps(BIT);
    chk("t1_drained", q.size(), 0);
    chk("t1_xfer", xfer_cnt, 1);
    chk("t1_vld_cycles", vld_hi, 1);
    chk("t1_flags", fe_cnt + brk_cnt + ovr_cnt, 0);

    // 2: low stop bit, then recovery
    clear();
    send(8'h3A, 1'b0);
    steps(2 * BIT);
    chk("t2_frame_err", fe_cnt, 1);
    chk("t2_no_vld", vld_hi, 0);
    chk("t2_no_break", brk_cnt, 0);
    q.push_back(8'hC3);
    send(8'hC3, 1'b1);
    steps(BIT);
    chk("t2_drained", q.size(), 0);
    chk("t2_xfer", xfer_cnt, 1);
    chk("t2_frame_err_once", fe_cnt, 1);

    // 3: short glitch is a false start
    clear();
    uart_rxd = 1'b0;
    steps(3);
    uart_rxd = 1'b1;
    steps(BIT);
    chk("t3_busy_seen", busy_cnt > 0, 1);
    chk("t3_busy_end", busy, 1'b0);
    chk("t3_no_vld", vld_hi, 0);
    chk("t3_flags", fe_cnt + brk_cnt + ovr_cnt, 0);

    // 4: fill the FIFO with the consumer stalled, one byte too many
    clear();
    dout_rdy = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) q.push_back(8'(i));
      send(8'(i), 1'b1);
    end
    steps(BIT);
    chk("t4_overrun", ovr_cnt, 1);
    chk("t4_no_xfer", xfer_cnt, 0);
    chk("t4_head", dout, 8'h01);
    chk("t4_vld", dout_vld, 1'b1);
    dout_rdy = 1'b1;
    steps(10);
    chk("t4_drained", q.size(), 0);
    chk("t4_xfer", xfer_cnt, 4);
    chk("t4_empty", dout_vld, 1'b0);
    chk("t4_overrun_once", ovr_cnt, 1);

    // 5: long break gives a single pulse
    clear();
    uart_rxd = 1'b0;
    steps(20 * BIT);
    uart_rxd = 1'b1;
    steps(2 * BIT);
    chk("t5_break", brk_cnt, 1);
    chk("t5_no_fe", fe_cnt, 0);
    chk("t5_no_vld", vld_hi, 0);
    q.push_back(8'hA5);
    send(8'hA5, 1'b1);
    steps(BIT);
    chk("t5_drained", q.size(), 0);
    chk("t5_xfer", xfer_cnt, 1);

    // 6: reset in the middle of a frame
    clear();
    uart_rxd = 1'b0;
    steps(BIT);
    for (int i = 0; i < 3; i++) begin
      uart_rxd = 1'b1;
      steps(BIT);
    end
    rst = 1'b1;
    uart_rxd = 1'b0;
    steps(2);
    uart_rxd = 1'b1;
    steps(2);
    chk_reset_outputs("t6_reset");
    rst = 1'b0;
    uart_rxd = 1'b0;
    steps(50);
    uart_rxd = 1'b1;
    steps(5 * BIT);
    steps(2 * BIT);
    chk("t6_no_partial", xfer_cnt, 0);
    q.push_back(8'h7E);
    send(8'h7E, 1'b1);
    steps(BIT);
    chk("t6_drained", q.size(), 0);
    chk("t6_xfer", xfer_cnt, 1);
    chk("t6_flags", fe_cnt + brk_cnt + ovr_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
